writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile_pkg.sv | 54 +++++
 rtl/writeback_regfile_if.sv | 29 ++
 rtl/writeback_regfile_regfile_2r2w.sv | 54 +++++
 rtl/writeback_regfile.sv | 68 ++++++
 tb/tb_writeback_regfile.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 retire definitions: icode constants, register specifiers,
// writeback state encoding and destination selection used by decode and writeback.
package writeback_regfile_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    // cmovXX retires as rrmovq; a false condition drops the E write entirely.
    function automatic logic [3:0] sel_dst_e(input logic [3:0] icode,
                                             input logic [3:0] rb,
                                             input logic       cnd);
        logic [3:0] dst;
        dst = RNONE;
        case (icode)
            I_RRMOVQ:                        dst = cnd ? rb : RNONE;
            I_IRMOVQ, I_OPQ:                 dst = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst = RRSP;
            default:                         dst = RNONE;
        endcase
        return dst;
    endfunction

    function automatic logic [3:0] sel_dst_m(input logic [3:0] icode,
                                             input logic [3:0] ra);
        logic [3:0] dst;
        dst = RNONE;
        if (icode == I_MRMOVQ || icode == I_POPQ) begin
            dst = ra;
        end
        return dst;
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Retire bus between the pipeline and the writeback/register-file block,
// including the decode-stage read ports and processor status.
interface writeback_regfile_if;

    logic [3:0]                              icode;
    logic [3:0]                              rA;
    logic [3:0]                              rB;
    logic                                    cnd;
    logic [writeback_regfile_pkg::DATA_W-1:0] valE;
    logic [writeback_regfile_pkg::DATA_W-1:0] valM;
    logic                                    wb_en;
    logic [3:0]                              rd_addr_a;
    logic [3:0]                              rd_addr_b;
    logic [writeback_regfile_pkg::DATA_W-1:0] rd_data_a;
    logic [writeback_regfile_pkg::DATA_W-1:0] rd_data_b;
    logic                                    halted;
    logic [63:0]                             retired;

    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, halted, retired
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, halted, retired
    );

endinterface

// File: rtl/writeback_regfile_regfile_2r2w.sv
// Fifteen-entry register array with two combinational read ports and two write
// ports; port M overrides port E when both target the same register.
module regfile_2r2w
    import writeback_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we_e,
    input  logic [3:0]        waddr_e,
    input  logic [DATA_W-1:0] wdata_e,
    input  logic              we_m,
    input  logic [3:0]        waddr_m,
    input  logic [DATA_W-1:0] wdata_m
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Reads come straight from the flops, so a same-cycle write shows only after the edge.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_addr_a == 4'(i)) rd_data_a = regs_q[i];
            if (rd_addr_b == 4'(i)) rd_data_b = regs_q[i];
        end
    end

    // Address RNONE never matches an index, so it silently writes nothing.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_e && waddr_e == 4'(i)) regs_d[i] = wdata_e;
            if (we_m && waddr_m == 4'(i)) regs_d[i] = wdata_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: picks E/M destinations, commits into the register file,
// counts retired instructions and stops the machine on halt.
module writeback_regfile
    import writeback_regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    writeback_regfile_if.slave  wb
);

    state_t      state_q, state_d;
    logic        halted_q;
    logic [63:0] retired_q, retired_d;
    logic        commit;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    assign commit = wb.wb_en && (state_q == S_RUN);
    assign dst_e  = sel_dst_e(wb.icode, wb.rB, wb.cnd);
    assign dst_m  = sel_dst_m(wb.icode, wb.rA);

    regfile_2r2w u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (wb.rd_addr_a),
        .rd_addr_b (wb.rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .we_e      (commit),
        .waddr_e   (dst_e),
        .wdata_e   (wb.valE),
        .we_m      (commit),
        .waddr_m   (dst_m),
        .wdata_m   (wb.valM)
    );

    // Halt itself is a counted commit; afterwards nothing is committed until reset.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        if (commit) begin
            retired_d = retired_q + 64'd1;
            if (wb.icode == I_HALT) begin
                state_d = S_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= (state_d == S_HALTED);
            retired_q <= retired_d;
        end
    end

    assign wb.rd_data_a = rd_data_a;
    assign wb.rd_data_b = rd_data_b;
    assign wb.halted    = halted_q;
    assign wb.retired   = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed retire scenarios plus
// randomized commits checked against an architectural register/counter model.
module tb_writeback_regfile;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    logic [63:0] rm_regs [15];
    logic        rm_halted;
    logic [63:0] rm_retired;

    writeback_regfile_if bus();

    writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 15; i++) rm_regs[i] = 64'd0;
        rm_halted  = 1'b0;
        rm_retired = 64'd0;
    endtask

    // Architectural effect of one rising edge, taken from the retire rules.
    task automatic model_edge();
        int de;
        int dm;
        if (rst || rm_halted || !bus.wb_en) return;
        rm_retired = rm_retired + 64'd1;
        if (bus.icode == 4'h0) begin
            rm_halted = 1'b1;
            return;
        end
        de = 15;
        dm = 15;
        case (int'(bus.icode))
            2:             de = bus.cnd ? int'(bus.rB) : 15;
            3, 6:          de = int'(bus.rB);
            8, 9, 10, 11:  de = 4;
            default:       de = 15;
        endcase
        if (bus.icode == 4'h5 || bus.icode == 4'hB) dm = int'(bus.rA);
        if (de != 15) rm_regs[de] = bus.valE;
        if (dm != 15) rm_regs[dm] = bus.valM;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm,
                         input logic en);
        @(negedge clk);
        bus.icode = ic;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.valE  = ve;
        bus.valM  = vm;
        bus.wb_en = en;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic read_a(input logic [3:0] addr, output logic [63:0] data);
        bus.rd_addr_a = addr;
        #1;
        data = bus.rd_data_a;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        rst = 1'b1;
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h77, 64'h0, 1'b1);
        step();
        checks++;
        if (bus.halted !== 1'b0) begin fails++; $display("FAIL reset_halted actual=%0b required=0", bus.halted); end
        checks++;
        if (bus.retired !== 64'd0) begin fails++; $display("FAIL reset_retired actual=%0d required=0", bus.retired); end
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i), d);
            checks++;
            if (d !== 64'd0) begin fails++; $display("FAIL reset_read r%0d actual=%h required=0", i, d); end
        end
        @(negedge clk);
        bus.wb_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_irmovq();
        logic [63:0] d;
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 1'b1);
        step();
        read_a(4'h2, d);
        checks++;
        if (d !== 64'h55) begin fails++; $display("FAIL irmovq_r2 actual=%h required=55", d); end
        checks++;
        if (bus.retired !== 64'd1) begin fails++; $display("FAIL irmovq_retired actual=%0d required=1", bus.retired); end
    endtask

    task automatic test_cmov();
        logic [63:0] d;
        drive(4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'h0, 1'b1);
        step();
        read_a(4'h3, d);
        checks++;
        if (d !== 64'd0) begin fails++; $display("FAIL cmov_false_r3 actual=%h required=0", d); end
        checks++;
        if (bus.retired !== 64'd2) begin fails++; $display("FAIL cmov_false_retired actual=%0d required=2", bus.retired); end
        drive(4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'h0, 1'b1);
        step();
        read_a(4'h3, d);
        checks++;
        if (d !== 64'd7) begin fails++; $display("FAIL cmov_true_r3 actual=%h required=7", d); end
    endtask

    task automatic test_pop();
        logic [63:0] d;
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200, 1'b1);
        step();
        read_a(4'h4, d);
        checks++;
        if (d !== 64'h200) begin fails++; $display("FAIL popq_rsp actual=%h required=200", d); end
        drive(4'h5, 4'h1, 4'hF, 1'b0, 64'h0, 64'd9, 1'b1);
        step();
        read_a(4'h1, d);
        checks++;
        if (d !== 64'd9) begin fails++; $display("FAIL mrmovq_r1 actual=%h required=9", d); end
        read_a(4'h4, d);
        checks++;
        if (d !== 64'h200) begin fails++; $display("FAIL mrmovq_r4_kept actual=%h required=200", d); end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        logic [63:0] cnt;
        drive(4'h6, 4'hF, 4'h2, 1'b0, 64'hAA, 64'h0, 1'b1);
        read_a(4'h2, d);
        checks++;
        if (d !== 64'h55) begin fails++; $display("FAIL same_cycle_pre_edge actual=%h required=55", d); end
        step();
        read_a(4'h2, d);
        checks++;
        if (d !== 64'hAA) begin fails++; $display("FAIL same_cycle_post_edge actual=%h required=aa", d); end
        cnt = bus.retired;
        drive(4'h6, 4'hF, 4'h2, 1'b0, 64'hBB, 64'h0, 1'b0);
        step();
        read_a(4'h2, d);
        checks++;
        if (d !== 64'hAA) begin fails++; $display("FAIL no_wb_en_data actual=%h required=aa", d); end
        checks++;
        if (bus.retired !== rm_retired || rm_retired !== cnt) begin
            fails++; $display("FAIL no_wb_en_count actual=%0d required=%0d", bus.retired, cnt);
        end
    endtask

    task automatic test_halt();
        logic [63:0] d;
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);
        step();
        checks++;
        if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_flag actual=%0b required=1", bus.halted); end
        checks++;
        if (bus.retired !== 64'd7) begin fails++; $display("FAIL halt_count actual=%0d required=7", bus.retired); end
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'd1, 64'h0, 1'b1);
        step();
        step();
        read_a(4'h5, d);
        checks++;
        if (d !== 64'd0) begin fails++; $display("FAIL halted_no_write actual=%h required=0", d); end
        checks++;
        if (bus.retired !== 64'd7) begin fails++; $display("FAIL halted_count_frozen actual=%0d required=7", bus.retired); end
        checks++;
        if (bus.halted !== 1'b1) begin fails++; $display("FAIL halted_sticky actual=%0b required=1", bus.halted); end
        @(negedge clk);
        bus.wb_en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [63:0] d;
        @(posedge clk);
        #20;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.halted !== 1'b0) begin fails++; $display("FAIL async_rst_halted actual=%0b required=0", bus.halted); end
        checks++;
        if (bus.retired !== 64'd0) begin fails++; $display("FAIL async_rst_retired actual=%0d required=0", bus.retired); end
        for (int i = 0; i < 15; i++) begin
            read_a(4'(i), d);
            checks++;
            if (d !== 64'd0) begin fails++; $display("FAIL async_rst_r%0d actual=%h required=0", i, d); end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] d;
        for (int n = 0; n < 200; n++) begin
            drive(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
            step();
            for (int i = 0; i < 15; i++) begin
                bus.rd_addr_b = 4'(14 - i);
                read_a(4'(i), d);
                checks++;
                if (d !== rm_regs[i] || bus.rd_data_b !== rm_regs[14 - i]) begin
                    fails++;
                    $display("FAIL random_regs cyc=%0d r%0d actual=%h/%h required=%h/%h", n, i,
                             d, bus.rd_data_b, rm_regs[i], rm_regs[14 - i]);
                end
            end
            read_a(4'hF, d);
            checks++;
            if (d !== 64'd0) begin fails++; $display("FAIL random_rnone actual=%h required=0", d); end
            checks++;
            if (bus.retired !== rm_retired || bus.halted !== rm_halted) begin
                fails++;
                $display("FAIL random_status cyc=%0d actual=%0d/%0b required=%0d/%0b", n,
                         bus.retired, bus.halted, rm_retired, rm_halted);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        model_reset();
        rst = 1'b1;
        bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
        bus.valE = 64'd0; bus.valM = 64'd0; bus.wb_en = 1'b0;
        bus.rd_addr_a = 4'h0; bus.rd_addr_b = 4'h0;
        test_reset();
        test_irmovq();
        test_cmov();
        test_pop();
        test_bypass();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
